// File: rtl/modaddsub_pkg.sv
// Shared constants for the modular add/subtract sequencer.
// States are plain localparams so legacy tools can consume this package.
package modaddsub_pkg;

  parameter int unsigned DefaultWidth = 1027;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StIssue1 = 3'd1;
  localparam state_t StWait1  = 3'd2;
  localparam state_t StIssue2 = 3'd3;
  localparam state_t StWait2  = 3'd4;
  localparam state_t StFin    = 3'd5;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/modaddsub_ctrl.sv
// Two-pass modular add/subtract sequencer driving one shared mpadder.
// Define MODADDSUB_CONST_TIME_EN to force the second pass on every operation.
module modaddsub_ctrl
  import modaddsub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH-1:0] add_in_a,
  output logic [WIDTH-1:0] add_in_b,
  input  logic [WIDTH:0]   add_result,
  input  logic             add_done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             op_q, op_d;
  logic             sub_q, sub_d;

  logic [WIDTH-1:0] sum_lo;
  logic             borrow;

  assign sum_lo = add_result[WIDTH-1:0];
  assign borrow = add_result[WIDTH];

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    t_d      = t_q;
    result_d = result_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    sub_d    = sub_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // First-pass operands are loaded straight into the adder registers.
          opa_d   = in_a;
          opb_d   = in_b;
          sub_d   = op_sub;
          m_d     = in_m;
          op_d    = op_sub;
          state_d = StIssue1;
        end
      end
      StIssue1: state_d = StWait1;
      StWait1: begin
        if (add_done) begin
          t_d   = sum_lo;
          opa_d = sum_lo;
          if (op_q == OP_ADD) begin
            opb_d   = m_q;
            sub_d   = 1'b1;
            state_d = StIssue2;
          end else if (borrow) begin
            opb_d   = m_q;
            sub_d   = 1'b0;
            state_d = StIssue2;
          end else begin
`ifdef MODADDSUB_CONST_TIME_EN
            // Dummy pass (T + 0) keeps latency and adder activity data-independent.
            opb_d   = '0;
            sub_d   = 1'b0;
            state_d = StIssue2;
`else
            result_d = sum_lo;
            state_d  = StFin;
`endif
          end
        end
      end
      StIssue2: state_d = StWait2;
      StWait2: begin
        if (add_done) begin
          // For add, a borrow on S-M means S was already reduced.
          result_d = (op_q == OP_ADD && borrow) ? t_q : sum_lo;
          state_d  = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      m_q      <= '0;
      t_q      <= '0;
      result_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= 1'b0;
      sub_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      t_q      <= t_d;
      result_q <= result_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      sub_q    <= sub_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StFin);
  assign add_start    = (state_q == StIssue1) || (state_q == StIssue2);
  assign add_subtract = sub_q;
  assign add_in_a     = opa_q;
  assign add_in_b     = opb_q;
  assign result       = result_q;

endmodule
